mem_port_scheduler: RTL and testbench
=====================================

// Module: mem_port_scheduler
// PURPOSE
// - Shares one downstream memory command/response port between NUM_REQ clients.
// - Rotating-priority (round-robin) command arbitration. The granted command is held stable until the port accepts it.
// - Tracks outstanding commands in an in-order ID queue and routes each response burst back to its issuer.
// - Sits between the shader-core load/store units and the memory interface.
// PARAMETERS
// - NUM_REQ   4    number of requesters
// - ADDR_W    32   command address width
// - LEN_W     4    burst-length field width (beats = len + 1)
// - DATA_W    32   response data width
// - MAX_OUTST 8    max outstanding commands; power of 2, >= 2
// PORTS
// - clk            in   1               single clock, rising edge
// - rst_n          in   1               synchronous, active-low reset
// - i_req_valid    in   NUM_REQ         per-requester command valid
// - i_req_addr     in   NUM_REQ*ADDR_W  packed addresses; requester k at [k*ADDR_W +: ADDR_W]
// - i_req_len      in   NUM_REQ*LEN_W   packed burst lengths
// - o_req_ready    out  NUM_REQ         command accepted (one-hot or zero)
// - o_mem_valid    out  1               downstream command valid
// - o_mem_addr     out  ADDR_W          downstream address
// - o_mem_len      out  LEN_W           downstream burst length
// - o_mem_src      out  $clog2(NUM_REQ) issuing requester index
// - i_mem_ready    in   1               downstream accepts command
// - i_rsp_valid    in   1               downstream response beat valid
// - i_rsp_data     in   DATA_W          response beat data
// - i_rsp_last     in   1               final beat of a burst
// - o_rsp_ready    out  1               response beat accepted
// - o_cl_rsp_valid out  NUM_REQ         one-hot response valid to the owning requester
// - o_cl_rsp_data  out  DATA_W          broadcast response data
// - o_cl_rsp_last  out  1               broadcast last flag
// - i_cl_rsp_ready in   NUM_REQ         per-requester response ready
// BEHAVIOUR
// - Reset (rst_n=0 at posedge):
//   - state=IDLE, priority pointer=0, ID queue empty.
//   - o_mem_valid=0, o_req_ready=0, o_rsp_ready=0, o_cl_rsp_valid=0.
//   - o_mem_addr/len/src=0.
// - Reset mid-operation: all in-flight state is dropped. Responses still arriving afterwards are unowned (see below).
// - FSM IDLE:
//   - If queue not full and |i_req_valid: pick the first set bit scanning from ptr upward, wrapping (ptr, ptr+1 .. NUM_REQ-1, 0 ..).
//   - Register the winner's index, addr and len into the command register; go to ISSUE.
//   - If the queue is full: stay in IDLE with no grant.
// - FSM ISSUE:
//   - o_mem_valid=1 with the registered fields, held stable until accepted.
//   - o_req_ready[sel] = i_mem_ready; all other bits 0.
//   - On i_mem_ready: push sel into the ID queue, set ptr = (sel+1) mod NUM_REQ, return to IDLE.
// - Latency: request valid -> o_mem_valid is 1 cycle. Maximum issue rate is one command per 2 cycles.
// - Client contract: i_req_valid/addr/len held until o_req_ready. A client that drops valid in ISSUE is a protocol error; the bench asserts on it.
// - Response routing:
//   - head = ID queue front.
//   - o_cl_rsp_valid[head] = i_rsp_valid & !empty.
//   - o_rsp_ready = !empty & i_cl_rsp_ready[head].
//   - Pop head on (i_rsp_valid & o_rsp_ready & i_rsp_last).
// - Empty queue: o_rsp_ready=0 and no o_cl_rsp_valid; unowned responses stall. The bench asserts that none arrive.
// - Push and pop in the same cycle: occupancy is unchanged; legal when full, since pop frees the slot the same edge.
// - Full is evaluated in IDLE only; at most one push is pending per ISSUE, so overflow is impossible.
// - Wrap-around: ptr wraps NUM_REQ-1 -> 0. Queue pointers are $clog2(MAX_OUTST)+1 bits for full/empty detection.
// - A requester issuing again while responses are owed is allowed; ordering is preserved by the queue.
// STRUCTURE
// - mem_sched_pkg:
//   - typedef enum logic {IDLE, ISSUE} sched_state_e
//   - localparams SRC_W=$clog2(NUM_REQ), QPTR_W
//   - typedef struct cmd_t {addr, len, src}
// - Sub-module id_fifo: sync FIFO, width SRC_W, depth MAX_OUTST; outputs full, empty, head. Instantiated once.
// - Round-robin pick is a combinational function in this module using a doubled request vector.
// TESTING
// - Reset, then req=4'b0000 for 5 cycles -> o_mem_valid=0, o_req_ready=0, o_rsp_ready=0 throughout.
// - req=4'b1111 held, i_mem_ready=1 -> issue order src 0,1,2,3,0; each grant pulse 2 cycles apart.
// - req=4'b0100, i_mem_ready=0 for 6 cycles -> o_mem_valid=1, addr/len/src=2 stable, o_req_ready=0 until ready.
// - Issue 8 commands with no responses (MAX_OUTST=8) -> 9th request gets no grant. One last-beat response -> 9th issues 2 cycles later.
// - Issue src 3 (len=2) then src 1 (len=0); 3 beats then 1 beat -> o_cl_rsp_valid=4'b1000 x3, then 4'b0010.
//   - With i_cl_rsp_ready[3]=0 for 2 cycles: o_rsp_ready=0 during the stall, and data is held.
// - Reset asserted in ISSUE with 3 outstanding -> next cycle IDLE, queue empty, o_mem_valid=0, ptr=0.

Source files
------------

// File: rtl/mem_sched_pkg.sv
// Shared widths, FSM encoding and command record for the memory port scheduler.
// Pure declarations: no latency and no flow control of its own.
package mem_sched_pkg;

    localparam int NUM_REQ   = 4;
    localparam int ADDR_W    = 32;
    localparam int LEN_W     = 4;
    localparam int DATA_W    = 32;
    localparam int MAX_OUTST = 8;
    localparam int SRC_W     = $clog2(NUM_REQ);
    localparam int QPTR_W    = $clog2(MAX_OUTST) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [SRC_W-1:0]  src;
    } cmd_t;

endpackage

// File: rtl/mem_port_scheduler_id_fifo.sv
// In-order queue of issuing requester IDs; push/pop take effect at the clock edge.
// No internal backpressure: the caller never pushes when full unless it pops in the same cycle.
module id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_i) wr_d = wr_q + 1'b1;
        if (pop_i)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= push_dat_i;
    end

    // Extra pointer MSB separates a full ring from an empty one.
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign head_o  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/mem_port_scheduler.sv
// Round-robin share of one memory command port; responses routed back in issue order.
// Request valid -> o_mem_valid in 1 cycle; command held until i_mem_ready; responses stall on client ready.
module mem_port_scheduler
    import mem_sched_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  i_req_len,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic                      o_mem_valid,
    output logic [ADDR_W-1:0]         o_mem_addr,
    output logic [LEN_W-1:0]          o_mem_len,
    output logic [SRC_W-1:0]          o_mem_src,
    input  logic                      i_mem_ready,
    input  logic                      i_rsp_valid,
    input  logic [DATA_W-1:0]         i_rsp_data,
    input  logic                      i_rsp_last,
    output logic                      o_rsp_ready,
    output logic [NUM_REQ-1:0]        o_cl_rsp_valid,
    output logic [DATA_W-1:0]         o_cl_rsp_data,
    output logic                      o_cl_rsp_last,
    input  logic [NUM_REQ-1:0]        i_cl_rsp_ready
);

    sched_state_e     state_q, state_d;
    logic [SRC_W-1:0] ptr_q, ptr_d;
    cmd_t             cmd_q, cmd_d;
    logic [SRC_W-1:0] win;
    logic [SRC_W-1:0] head;
    logic             q_full, q_empty, push, pop;

    // Rotate the doubled request vector so bit 0 is the current priority holder.
    function automatic logic [SRC_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [SRC_W-1:0]   ptr);
        logic [NUM_REQ-1:0] rot;
        logic [SRC_W-1:0]   idx;
        rot = NUM_REQ'({req, req} >> ptr);
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) idx = SRC_W'((int'(ptr) + i) % NUM_REQ);
        end
        return idx;
    endfunction

    assign win = rr_pick(i_req_valid, ptr_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cmd_q   <= cmd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cmd_d   = cmd_q;
        case (state_q)
            IDLE: begin
                if (!q_full && (|i_req_valid)) begin
                    cmd_d.addr = i_req_addr[win*ADDR_W +: ADDR_W];
                    cmd_d.len  = i_req_len[win*LEN_W +: LEN_W];
                    cmd_d.src  = win;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (i_mem_ready) begin
                    ptr_d   = SRC_W'((int'(cmd_q.src) + 1) % NUM_REQ);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_mem_valid = (state_q == ISSUE);
        o_mem_addr  = cmd_q.addr;
        o_mem_len   = cmd_q.len;
        o_mem_src   = cmd_q.src;
        o_req_ready = '0;
        push        = 1'b0;
        if (state_q == ISSUE && i_mem_ready) begin
            o_req_ready[cmd_q.src] = 1'b1;
            push                   = 1'b1;
        end
    end

    always_comb begin
        o_cl_rsp_valid = '0;
        o_rsp_ready    = !q_empty && i_cl_rsp_ready[head];
        if (i_rsp_valid && !q_empty) o_cl_rsp_valid[head] = 1'b1;
        pop = i_rsp_valid && o_rsp_ready && i_rsp_last;
    end

    assign o_cl_rsp_data = i_rsp_data;
    assign o_cl_rsp_last = i_rsp_last;

    id_fifo #(
        .WIDTH (SRC_W),
        .DEPTH (MAX_OUTST)
    ) u_id_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i (cmd_q.src),
        .pop_i      (pop),
        .full_o     (q_full),
        .empty_o    (q_empty),
        .head_o     (head)
    );

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Randomized and directed stimulus for mem_port_scheduler against a queue-based reference model.
module tb_mem_port_scheduler;

    localparam int NR   = 4;
    localparam int MAXO = 8;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_addr [NR];
    logic [3:0]  req_len  [NR];
    logic [127:0] req_addr_bus;
    logic [15:0] req_len_bus;
    logic        mem_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic [3:0]  cl_ready;

    logic [3:0]  o_req_ready;
    logic        o_mem_valid;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_len;
    logic [1:0]  o_mem_src;
    logic        o_rsp_ready;
    logic [3:0]  o_cl_rsp_valid;
    logic [31:0] o_cl_rsp_data;
    logic        o_cl_rsp_last;

    always_comb begin
        req_addr_bus = '0;
        req_len_bus  = '0;
        for (int k = 0; k < NR; k++) begin
            req_addr_bus[k*32 +: 32] = req_addr[k];
            req_len_bus[k*4 +: 4]    = req_len[k];
        end
    end

    mem_port_scheduler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req_valid    (req_valid),
        .i_req_addr     (req_addr_bus),
        .i_req_len      (req_len_bus),
        .o_req_ready    (o_req_ready),
        .o_mem_valid    (o_mem_valid),
        .o_mem_addr     (o_mem_addr),
        .o_mem_len      (o_mem_len),
        .o_mem_src      (o_mem_src),
        .i_mem_ready    (mem_ready),
        .i_rsp_valid    (rsp_valid),
        .i_rsp_data     (rsp_data),
        .i_rsp_last     (rsp_last),
        .o_rsp_ready    (o_rsp_ready),
        .o_cl_rsp_valid (o_cl_rsp_valid),
        .o_cl_rsp_data  (o_cl_rsp_data),
        .o_cl_rsp_last  (o_cl_rsp_last),
        .i_cl_rsp_ready (cl_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one pending command slot plus a queue of owed bursts.
    typedef struct {
        int src;
        int rem;
    } owe_t;

    bit          m_busy = 1'b0;
    int          m_ptr  = 0;
    int          m_src  = 0;
    logic [31:0] m_addr = '0;
    logic [3:0]  m_len  = '0;
    owe_t        m_q [$];

    int  n_vec = 0;
    int  n_err = 0;
    int  cyc   = 0;
    int  refill_mode = 0;
    bit  force_len0  = 1'b0;
    int  grant_log [$];
    int  grant_cyc [$];

    logic       obs_mem_valid;
    logic [3:0] obs_req_ready;
    logic       obs_rsp_ready;
    logic [3:0] obs_cl_valid;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic new_req(input int k);
        req_valid[k] = 1'b1;
        req_addr[k]  = $urandom;
        req_len[k]   = force_len0 ? 4'd0 : 4'($urandom_range(0, 3));
    endtask

    task automatic step();
        logic [3:0] exp_rr, exp_cl;
        bit   has, acc, fire, start, found;
        int   head, acc_k, w;
        owe_t e;
        @(negedge clk);
        #1;
        has    = (m_q.size() > 0);
        head   = has ? m_q[0].src : 0;
        exp_rr = (m_busy && mem_ready) ? 4'(1 << m_src) : 4'b0;
        exp_cl = (rsp_valid && has) ? 4'(1 << head) : 4'b0;
        obs_mem_valid = o_mem_valid;
        obs_req_ready = o_req_ready;
        obs_rsp_ready = o_rsp_ready;
        obs_cl_valid  = o_cl_rsp_valid;
        chk("mem_valid", obs_mem_valid, m_busy);
        if (m_busy) begin
            chk("mem_addr", o_mem_addr, m_addr);
            chk("mem_len", o_mem_len, m_len);
            chk("mem_src", o_mem_src, m_src);
        end
        chk("req_ready", obs_req_ready, exp_rr);
        chk("rsp_ready", obs_rsp_ready, has && cl_ready[head]);
        chk("cl_valid", obs_cl_valid, exp_cl);
        if (exp_cl != 0) begin
            chk("cl_data", o_cl_rsp_data, rsp_data);
            chk("cl_last", o_cl_rsp_last, rsp_last);
        end
        if (rst_n) begin
            assert (!(m_busy && !req_valid[m_src]))
                else $error("protocol: requester %0d dropped valid while its command is pending", m_src);
            assert (!(rsp_valid && !has))
                else $error("protocol: response beat with no outstanding command");
        end
        for (int k = 0; k < NR; k++) begin
            if (obs_req_ready[k]) begin
                grant_log.push_back(k);
                grant_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        acc = 1'b0; fire = 1'b0; acc_k = 0; w = 0; found = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_ptr  = 0;
            m_q.delete();
        end else begin
            acc   = m_busy && mem_ready;
            fire  = rsp_valid && has && cl_ready[head];
            start = !m_busy && (m_q.size() < MAXO) && (req_valid != 0);
            if (fire) begin
                if (rsp_last) void'(m_q.pop_front());
                else m_q[0].rem = m_q[0].rem - 1;
            end
            if (acc) begin
                e.src = m_src;
                e.rem = int'(m_len) + 1;
                m_q.push_back(e);
                m_ptr  = (m_src + 1) % NR;
                m_busy = 1'b0;
                acc_k  = m_src;
            end else if (start) begin
                for (int k = 0; k < NR; k++) begin
                    if (!found && req_valid[(m_ptr + k) % NR]) begin
                        w = (m_ptr + k) % NR;
                        found = 1'b1;
                    end
                end
                m_busy = 1'b1;
                m_src  = w;
                m_addr = req_addr[w];
                m_len  = req_len[w];
            end
        end
        cyc++;
        #1;
        if (!rst_n) begin
            req_valid = '0;
            rsp_valid = 1'b0;
        end
        if (acc) begin
            if (refill_mode == 0) req_valid[acc_k] = 1'b0;
            else if (refill_mode == 2) new_req(acc_k);
        end
        if (fire) rsp_valid = 1'b0;
    endtask

    task automatic quiesce();
        refill_mode = 0;
        mem_ready   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < NR; k++)
                if (!(m_busy && k == m_src)) req_valid[k] = 1'b0;
            if (!m_busy) break;
            step();
        end
    endtask

    task automatic drain();
        mem_ready = 1'b1;
        cl_ready  = 4'hF;
        for (int i = 0; i < 400 && (m_q.size() > 0 || m_busy); i++) begin
            if (m_q.size() > 0 && !rsp_valid) begin
                rsp_valid = 1'b1;
                rsp_data  = $urandom;
            end
            if (rsp_valid) rsp_last = (m_q[0].rem == 1);
            step();
        end
        rsp_valid = 1'b0;
        step();
        chk("drain_empty", obs_rsp_ready, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        rst_n = 1'b0; req_valid = '0; mem_ready = 1'b0;
        rsp_valid = 1'b0; rsp_data = '0; rsp_last = 1'b0; cl_ready = '0;
        for (int k = 0; k < NR; k++) begin
            req_addr[k] = '0;
            req_len[k]  = '0;
        end
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then idle with no requests
        step();
        chk("rst_addr", o_mem_addr, 32'h0);
        chk("rst_len", o_mem_len, 4'h0);
        chk("rst_src", o_mem_src, 2'h0);
        rst_n = 1'b1;
        cl_ready = 4'hF;
        repeat (5) begin
            step();
            chk("idle_mem_valid", obs_mem_valid, 1'b0);
            chk("idle_req_ready", obs_req_ready, 4'h0);
            chk("idle_rsp_ready", obs_rsp_ready, 1'b0);
        end

        // All four requesting: grants rotate 0,1,2,3,0 two cycles apart
        refill_mode = 1;
        mem_ready   = 1'b1;
        for (int k = 0; k < NR; k++) begin
            req_valid[k] = 1'b1;
            req_addr[k]  = 32'h1000 * (k + 1);
            req_len[k]   = 4'(k);
        end
        grant_log.delete();
        grant_cyc.delete();
        repeat (10) step();
        chk("rr_count", grant_log.size(), 5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
            chk("rr_order", grant_log[i], exp_order[i]);
            if (i > 0) chk("rr_gap", grant_cyc[i] - grant_cyc[i-1], 2);
        end
        quiesce();
        drain();

        // Single requester stalled by the port: command held stable
        req_valid   = 4'b0100;
        req_addr[2] = 32'h2;
        req_len[2]  = 4'h2;
        mem_ready   = 1'b0;
        step();
        repeat (6) begin
            step();
            chk("stall_valid", obs_mem_valid, 1'b1);
            chk("stall_src", o_mem_src, 2'd2);
            chk("stall_addr", o_mem_addr, 32'h2);
            chk("stall_len", o_mem_len, 4'h2);
            chk("stall_rdy", obs_req_ready, 4'h0);
        end
        mem_ready = 1'b1;
        step();
        chk("stall_grant", obs_req_ready, 4'b0100);
        quiesce();
        drain();

        // Fill the ID queue; the ninth request waits for one completed burst
        force_len0  = 1'b1;
        refill_mode = 2;
        mem_ready   = 1'b1;
        for (int k = 0; k < NR; k++) new_req(k);
        for (int i = 0; i < 60 && m_q.size() < MAXO; i++) step();
        repeat (6) begin
            step();
            chk("full_nogrant", obs_mem_valid, 1'b0);
        end
        rsp_valid = 1'b1; rsp_data = $urandom; rsp_last = 1'b1;
        step();
        rsp_valid = 1'b0;
        step();
        chk("full_c1", obs_mem_valid, 1'b0);
        step();
        chk("full_c2", obs_mem_valid, 1'b1);
        chk("full_c2_grant", obs_req_ready != 0, 1'b1);
        quiesce();
        drain();
        force_len0 = 1'b0;

        // Ordered routing: src3 3-beat burst, then src1 single beat, with a client stall
        req_valid   = 4'b1000;
        req_addr[3] = 32'h3333;
        req_len[3]  = 4'd2;
        for (int i = 0; i < 10 && m_q.size() < 1; i++) step();
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h1111;
        req_len[1]   = 4'd0;
        for (int i = 0; i < 10 && m_q.size() < 2; i++) step();
        quiesce();
        cl_ready = 4'hF;
        rsp_valid = 1'b1; rsp_data = 32'hA0A0_0001; rsp_last = 1'b0;
        step();
        chk("route_b1", obs_cl_valid, 4'b1000);
        chk("route_b1_rdy", obs_rsp_ready, 1'b1);
        cl_ready = 4'b0111;
        repeat (2) begin
            rsp_valid = 1'b1; rsp_data = 32'hA0A0_0002; rsp_last = 1'b0;
            step();
            chk("route_stall_rdy", obs_rsp_ready, 1'b0);
            chk("route_stall_vld", obs_cl_valid, 4'b1000);
            chk("route_stall_dat", o_cl_rsp_data, 32'hA0A0_0002);
        end
        cl_ready = 4'hF;
        step();
        chk("route_b2_rdy", obs_rsp_ready, 1'b1);
        rsp_valid = 1'b1; rsp_data = 32'hA0A0_0003; rsp_last = 1'b1;
        step();
        chk("route_b3", obs_cl_valid, 4'b1000);
        chk("route_b3_last", o_cl_rsp_last, 1'b1);
        rsp_valid = 1'b1; rsp_data = 32'hB0B0_0001; rsp_last = 1'b1;
        step();
        chk("route_src1", obs_cl_valid, 4'b0010);
        drain();

        // Reset in ISSUE with three outstanding
        refill_mode = 2;
        mem_ready   = 1'b1;
        for (int k = 0; k < NR; k++) new_req(k);
        for (int i = 0; i < 30 && m_q.size() < 3; i++) step();
        mem_ready = 1'b0;
        for (int i = 0; i < 10 && !m_busy; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        refill_mode = 0;
        cl_ready = 4'hF;
        step();
        chk("rst_mid_valid", obs_mem_valid, 1'b0);
        chk("rst_mid_qempty", obs_rsp_ready, 1'b0);
        req_valid = 4'hF;
        mem_ready = 1'b1;
        step();
        step();
        chk("rst_mid_ptr", obs_req_ready, 4'b0001);
        quiesce();
        drain();

        // Random traffic
        refill_mode = 2;
        for (int t = 0; t < 1500; t++) begin
            for (int k = 0; k < NR; k++)
                if (!req_valid[k] && ($urandom_range(0, 3) == 0)) new_req(k);
            mem_ready = ($urandom_range(0, 2) != 0);
            cl_ready  = 4'($urandom);
            if (!rsp_valid && m_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                rsp_valid = 1'b1;
                rsp_data  = $urandom;
            end
            if (rsp_valid) rsp_last = (m_q[0].rem == 1);
            step();
        end
        quiesce();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
